mem_stage_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MEM stage. It holds instruction memory, with a registered fetch into Q101H, and a byte-addressable data memory with configurable access latency. Load/store handling includes size encoding, sign extension, a stall handshake and misaligned/out-of-range fault detection. It sits between EXE (Q102H) and WB (Q104H) and stalls the upstream pipeline while an access is in flight.

---
 rtl/mem_stage_mc.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: registered instruction fetch plus a byte-addressable data
// memory with configurable latency, size/sign handling, stall and fault reporting.
module mem_stage_mc #(
    parameter int unsigned IMEM_SIZE_WORDS = 256,
    parameter int unsigned DMEM_SIZE_BYTES = 1024,
    parameter int unsigned DMEM_LATENCY    = 1,
    parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_Q100H,
    input  logic        ready_Q101H,
    output logic [31:0] instruction_Q101H,
    input  logic        req_valid_Q103H,
    input  logic        req_is_store_Q103H,
    input  logic [1:0]  req_size_Q103H,
    input  logic        req_is_signed_Q103H,
    input  logic [31:0] alu_out_Q103H,
    input  logic [31:0] dmem_wr_data_Q103H,
    input  logic        flush_Q103H,
    output logic        stall_Q103H,
    output logic        rd_valid_Q104H,
    output logic [31:0] dmem_rd_data_Q104H,
    output logic        fault_Q104H
);

    localparam int unsigned IW = (IMEM_SIZE_WORDS > 1) ? $clog2(IMEM_SIZE_WORDS) : 1;
    localparam int unsigned DW = (DMEM_SIZE_BYTES > 1) ? $clog2(DMEM_SIZE_BYTES) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(DMEM_LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_next;

    logic [31:0] imem [IMEM_SIZE_WORDS];
    logic [7:0]  dmem [DMEM_SIZE_BYTES];

    logic [IW-1:0] imem_idx;
    logic          unused_pc_bits;

    logic [2:0]    access_bytes;
    logic [32:0]   end_addr;
    logic          misaligned;
    logic          req_fault;
    logic          accept;
    logic          go;
    logic [DW-1:0] req_addr;

    logic [3:0]    cnt;
    logic          pend_load;
    logic [DW-1:0] cap_addr;
    logic [1:0]    cap_size;
    logic          cap_signed;

    // ---------------------------------------------------------------- fetch
    assign imem_idx       = IW'(pc_Q100H[31:2] % 30'(IMEM_SIZE_WORDS));
    assign unused_pc_bits = ^pc_Q100H[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_Q101H <= NOP_INSTR;
        end else if (ready_Q101H) begin
            instruction_Q101H <= imem[imem_idx];
        end
    end

    // --------------------------------------------------- request qualification
    always_comb begin
        access_bytes = 3'd0;
        case (req_size_Q103H)
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            2'b10:   access_bytes = 3'd4;
            default: access_bytes = 3'd0;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign end_addr   = {1'b0, alu_out_Q103H} + 33'(access_bytes);
    assign misaligned = (req_size_Q103H == 2'b01 && alu_out_Q103H[0])
                     || (req_size_Q103H == 2'b10 && alu_out_Q103H[1:0] != 2'b00)
                     || (req_size_Q103H == 2'b11);
    assign req_fault  = misaligned || (end_addr > 33'(DMEM_SIZE_BYTES));
    assign accept     = (state == IDLE) && req_valid_Q103H && !flush_Q103H;
    assign go         = accept && !req_fault;
    assign req_addr   = alu_out_Q103H[DW-1:0];

    assign stall_Q103H = (go && DMEM_LATENCY > 1) || (state == BUSY);

    function automatic logic [31:0] load_value(input logic [DW-1:0] a,
                                               input logic [1:0]    sz,
                                               input logic          sgn);
        logic [31:0] r;
        r = '0;
        case (sz)
            2'b00:   r = {{24{sgn & dmem[a][7]}}, dmem[a]};
            2'b01:   r = {{16{sgn & dmem[a + DW'(1)][7]}}, dmem[a + DW'(1)], dmem[a]};
            default: r = {dmem[a + DW'(3)], dmem[a + DW'(2)], dmem[a + DW'(1)], dmem[a]};
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------- data memory
    always_ff @(posedge clk) begin
        if (go && req_is_store_Q103H) begin
            dmem[req_addr] <= dmem_wr_data_Q103H[7:0];
            if (req_size_Q103H != 2'b00) begin
                dmem[req_addr + DW'(1)] <= dmem_wr_data_Q103H[15:8];
            end
            if (req_size_Q103H == 2'b10) begin
                dmem[req_addr + DW'(2)] <= dmem_wr_data_Q103H[23:16];
                dmem[req_addr + DW'(3)] <= dmem_wr_data_Q103H[31:24];
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    // BUSY covers only the stalling cycles; the final counter cycle (cnt == 1)
    // runs in IDLE so a fresh request offered while stall is low is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go && DMEM_LATENCY > 2) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush_Q103H || cnt == 4'd2) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------ counter and result path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                <= '0;
            pend_load          <= 1'b0;
            cap_addr           <= '0;
            cap_size           <= '0;
            cap_signed         <= 1'b0;
            rd_valid_Q104H     <= 1'b0;
            dmem_rd_data_Q104H <= '0;
            fault_Q104H        <= 1'b0;
        end else begin
            rd_valid_Q104H <= 1'b0;
            fault_Q104H    <= accept && req_fault;

            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (DMEM_LATENCY == 1) begin
                if (go && !req_is_store_Q103H) begin
                    rd_valid_Q104H     <= 1'b1;
                    dmem_rd_data_Q104H <= load_value(req_addr, req_size_Q103H,
                                                     req_is_signed_Q103H);
                end
            end else begin
                if (state == BUSY && flush_Q103H) begin
                    pend_load <= 1'b0;
                    cnt       <= '0;
                end else if (cnt == 4'd1 && pend_load) begin
                    rd_valid_Q104H     <= 1'b1;
                    dmem_rd_data_Q104H <= load_value(cap_addr, cap_size, cap_signed);
                    pend_load          <= 1'b0;
                end
                if (go) begin
                    cnt        <= CNT_INIT;
                    pend_load  <= !req_is_store_Q103H;
                    cap_addr   <= req_addr;
                    cap_size   <= req_size_Q103H;
                    cap_signed <= req_is_signed_Q103H;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: latency-1 and latency-4 instances driven with
// directed and random requests, compared against a byte-array reference model.
`timescale 1ns/1ps
module tb_mem_stage_mc;

    localparam int unsigned DSIZE = 1024;
    localparam int unsigned ISIZE = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, ready, flush;
    logic [31:0] pc, addr, wdata;
    logic        req_valid, is_store, is_signed;
    logic [1:0]  size;

    logic [31:0] instr1, instr4, rdata1, rdata4;
    logic        stall1, stall4, rv1, rv4, flt1, flt4;
    logic        v1, v4, fl1, fl4;
    logic        stall, rv, flt;
    logic [31:0] rdata;

    assign v1    = req_valid & ~sel;
    assign v4    = req_valid & sel;
    assign fl1   = flush & ~sel;
    assign fl4   = flush & sel;
    assign stall = sel ? stall4 : stall1;
    assign rv    = sel ? rv4 : rv1;
    assign flt   = sel ? flt4 : flt1;
    assign rdata = sel ? rdata4 : rdata1;

    mem_stage_mc #(.DMEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .pc_Q100H(pc), .ready_Q101H(ready),
        .instruction_Q101H(instr1), .req_valid_Q103H(v1),
        .req_is_store_Q103H(is_store), .req_size_Q103H(size),
        .req_is_signed_Q103H(is_signed), .alu_out_Q103H(addr),
        .dmem_wr_data_Q103H(wdata), .flush_Q103H(fl1), .stall_Q103H(stall1),
        .rd_valid_Q104H(rv1), .dmem_rd_data_Q104H(rdata1), .fault_Q104H(flt1)
    );

    mem_stage_mc #(.DMEM_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .pc_Q100H(pc), .ready_Q101H(ready),
        .instruction_Q101H(instr4), .req_valid_Q103H(v4),
        .req_is_store_Q103H(is_store), .req_size_Q103H(size),
        .req_is_signed_Q103H(is_signed), .alu_out_Q103H(addr),
        .dmem_wr_data_Q103H(wdata), .flush_Q103H(fl4), .stall_Q103H(stall4),
        .rd_valid_Q104H(rv4), .dmem_rd_data_Q104H(rdata4), .fault_Q104H(flt4)
    );

    logic [7:0]  mmem [2][DSIZE];
    logic [31:0] mimem [ISIZE];
    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
        longint unsigned n  = longint'(1) << sz;
        longint unsigned aa = a;
        if (sz == 2'd3) return 1'b1;
        if (aa % n != 0) return 1'b1;
        return (aa + n) > DSIZE;
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [1:0] sz,
                                               input logic sgn, input logic [31:0] a);
        longint n = longint'(1) << sz;
        longint v = 0;
        for (int i = 0; i < n; i++) begin
            v += longint'(mmem[s][a + i]) << (8 * i);
        end
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) begin
            v -= (longint'(1) << (8 * n));
        end
        return 32'(v);
    endfunction

    task automatic model_store(input int s, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            mmem[s][a + i] = 8'(wd >> (8 * i));
        end
    endtask

    // One request from offer to the end of its latency window, checking every cycle.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd);
        int          s  = sel ? 1 : 0;
        int unsigned L  = sel ? 4 : 1;
        bit          f  = model_fault(sz, a);
        bit          ld = !st && !f;
        logic [31:0] exp_data = '0;
        check("rv_idle", {31'b0, rv}, 32'd0);
        req_valid = 1'b1; is_store = st; size = sz; is_signed = sgn; addr = a; wdata = wd;
        #3;
        check("stall_acc", {31'b0, stall}, {31'b0, (!f && L > 1)});
        if (ld) exp_data = model_load(s, sz, sgn, a);
        if (!f && st) model_store(s, sz, a, wd);
        tick();
        for (int unsigned k = 1; k <= L; k++) begin
            check("rd_valid", {31'b0, rv}, {31'b0, (ld && k == L)});
            if (ld && k == L) check("rd_data", rdata, exp_data);
            check("fault", {31'b0, flt}, {31'b0, (f && k == 1)});
            if (k + 1 < L && !f) begin
                req_valid = 1'b1;
                is_store  = 1'($urandom_range(0, 1));
                size      = 2'($urandom_range(0, 3));
                is_signed = 1'($urandom_range(0, 1));
                addr      = $urandom_range(0, DSIZE - 4);
                wdata     = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            #3;
            check("stall", {31'b0, stall}, {31'b0, (!f && k + 1 < L)});
            tick();
        end
    endtask

    task automatic rand_req();
        logic [1:0]  sz;
        logic [31:0] a;
        int unsigned r = $urandom_range(0, 9);
        sz = (r < 9) ? 2'(r % 3) : 2'd3;
        a  = $urandom_range(0, DSIZE + 3);
        if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
        end
        if ($urandom_range(0, 19) == 0) a = $urandom | 32'hFFFF0000;
        do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_instr;
        rst = 1'b1; sel = 1'b0; ready = 1'b0; flush = 1'b0; pc = '0;
        req_valid = 1'b0; is_store = 1'b0; size = '0; is_signed = 1'b0;
        addr = '0; wdata = '0;
        for (int i = 0; i < ISIZE; i++) begin
            mimem[i] = $urandom;
        end
        mimem[5] = 32'h00A00093;
        for (int i = 0; i < ISIZE; i++) begin
            dut1.imem[i] = mimem[i];
            dut4.imem[i] = mimem[i];
        end
        #1;
        check("rst_instr1", instr1, NOP);
        check("rst_instr4", instr4, NOP);
        check("rst_stall1", {31'b0, stall1}, 32'd0);
        check("rst_stall4", {31'b0, stall4}, 32'd0);
        check("rst_rv1", {31'b0, rv1}, 32'd0);
        check("rst_rv4", {31'b0, rv4}, 32'd0);
        check("rst_data1", rdata1, 32'd0);
        check("rst_data4", rdata4, 32'd0);
        check("rst_fault1", {31'b0, flt1}, 32'd0);
        check("rst_fault4", {31'b0, flt4}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // fetch: directed, hold, then random with wrap-around of the word index
        pc = 32'h14; ready = 1'b1;
        tick();
        check("fetch5_1", instr1, 32'h00A00093);
        check("fetch5_4", instr4, 32'h00A00093);
        exp_instr = mimem[5];
        pc = 32'h20; ready = 1'b0;
        tick();
        check("fetch_hold1", instr1, exp_instr);
        check("fetch_hold4", instr4, exp_instr);
        for (int i = 0; i < 30; i++) begin
            pc = $urandom; ready = 1'($urandom_range(0, 1));
            if (ready) exp_instr = mimem[(pc >> 2) % ISIZE];
            tick();
            check("fetch_rand1", instr1, exp_instr);
            check("fetch_rand4", instr4, exp_instr);
        end
        ready = 1'b0;

        // give every byte a known value
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < DSIZE / 4; w++) begin
                do_req(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
            end
        end

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
            do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);
            do_req(1'b0, 2'd0, 1'b1, 32'h13, '0);
            do_req(1'b0, 2'd0, 1'b0, 32'h13, '0);
            do_req(1'b0, 2'd1, 1'b1, 32'h12, '0);
            do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h11112222);
            do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h33334444);
            do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55556666);
            do_req(1'b1, 2'd2, 1'b0, DSIZE - 2, 32'h77778888);
            do_req(1'b0, 2'd2, 1'b0, DSIZE - 2, '0);
            do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);
            do_req(1'b0, 2'd2, 1'b0, 32'h14, '0);
            do_req(1'b0, 2'd2, 1'b0, DSIZE - 4, '0);
        end

        // flush two cycles into a latency-4 load
        sel = 1'b1;
        req_valid = 1'b1; is_store = 1'b0; size = 2'd2; is_signed = 1'b0; addr = 32'h10;
        #3;
        check("fl_stall0", {31'b0, stall}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_rv3", {31'b0, rv}, 32'd0);
        #3;
        check("fl_stall3", {31'b0, stall}, 32'd0);
        tick();
        do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);

        // flush while idle drops the offered store entirely
        req_valid = 1'b1; is_store = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h12345678;
        flush = 1'b1;
        #3;
        check("fli_stall", {31'b0, stall}, 32'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("fli_fault", {31'b0, flt}, 32'd0);
        check("fli_rv", {31'b0, rv}, 32'd0);
        tick();
        do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 120; i++) begin
                rand_req();
            end
        end

        // asynchronous reset in the middle of a latency-4 load
        sel = 1'b1;
        req_valid = 1'b1; is_store = 1'b0; size = 2'd2; is_signed = 1'b0; addr = 32'h20;
        tick();
        req_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("mrst_instr1", instr1, NOP);
        check("mrst_instr4", instr4, NOP);
        check("mrst_stall", {31'b0, stall4}, 32'd0);
        check("mrst_rv", {31'b0, rv4}, 32'd0);
        check("mrst_fault", {31'b0, flt4}, 32'd0);
        check("mrst_data", rdata4, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mrst_rv_after", {31'b0, rv4}, 32'd0);
            check("mrst_stall_after", {31'b0, stall4}, 32'd0);
            tick();
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
